// File: rtl/spi_reg_writer.sv
// SPI mode-0 write-frame receiver that maintains the five 8-bit PWM configuration registers.
// Define SPI_READBACK_EN to build the CIPO readback shifter; otherwise cipo is tied low.
module spi_reg_writer (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_OVERRUN
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [15:0] shift_q, shift_nxt;
    logic        commit;
    logic        err_nxt;

    logic sclk_s1, sclk_s2, sclk_h;
    logic copi_s1, copi_s2, copi_h;
    logic ncs_s1, ncs_s2, ncs_h;
    logic sclk_rise, ncs_rise;
    logic settle, armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_h  <= 1'b0;
            copi_s1 <= 1'b0;
            copi_s2 <= 1'b0;
            copi_h  <= 1'b0;
            ncs_s1  <= 1'b1;
            ncs_s2  <= 1'b1;
            ncs_h   <= 1'b1;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            copi_s1 <= copi;
            copi_s2 <= copi_s1;
            copi_h  <= copi_s2;
            ncs_s1  <= ncs;
            ncs_s2  <= ncs_s1;
            ncs_h   <= ncs_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign ncs_rise  = ncs_s2 & ~ncs_h;

    // The ncs preset looks like "deselected" even if the pin is low, so a frame may
    // only start once a genuine post-reset sample of ncs has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle <= 1'b0;
            armed  <= 1'b0;
        end else begin
            settle <= 1'b1;
            if (settle && ncs_s1)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 5'd0;
            shift_q <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shift_q <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift_q;
        commit    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 5'd0;
                if (armed && !ncs_s2)
                    state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (ncs_rise) begin
                    state_nxt = ST_IDLE;
                    if (cnt == 5'd16)
                        commit = shift_q[15] && (shift_q[14:8] <= 7'd4);
                    else if (cnt != 5'd0)
                        err_nxt = 1'b1;
                end else if (sclk_rise) begin
                    if (cnt == 5'd16) begin
                        state_nxt = ST_OVERRUN;
                    end else begin
                        shift_nxt = {shift_q[14:0], copi_h};
                        cnt_nxt   = cnt + 5'd1;
                    end
                end
            end
            ST_OVERRUN: begin
                if (ncs_rise) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            frame_err       <= 1'b0;
        end else begin
            frame_err <= err_nxt;
            if (commit) begin
                case (shift_q[10:8])
                    3'd0:    en_reg_out_7_0  <= shift_q[7:0];
                    3'd1:    en_reg_out_15_8 <= shift_q[7:0];
                    3'd2:    en_reg_pwm_7_0  <= shift_q[7:0];
                    3'd3:    en_reg_pwm_15_8 <= shift_q[7:0];
                    3'd4:    pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic       rb_load;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;
    logic [7:0] rb_q;

    assign sclk_fall = ~sclk_s2 & sclk_h;

    // The 8th bit completes R/W and address: R/W sits in shift_q[6], the address
    // ends with the bit arriving now.
    always_comb begin
        rb_load = (state == ST_ACTIVE) && !ncs_rise && sclk_rise && (cnt == 5'd7);
        rd_addr = {shift_q[5:0], copi_h};
        case (rd_addr)
            7'd0:    rd_val = en_reg_out_7_0;
            7'd1:    rd_val = en_reg_out_15_8;
            7'd2:    rd_val = en_reg_pwm_7_0;
            7'd3:    rd_val = en_reg_pwm_15_8;
            7'd4:    rd_val = pwm_duty_cycle;
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE)
            rb_q <= 8'h00;
        else if (rb_load)
            rb_q <= shift_q[6] ? 8'h00 : rd_val;
        else if (state == ST_ACTIVE && sclk_fall && cnt >= 5'd9)
            rb_q <= {rb_q[6:0], 1'b0};
    end

    assign cipo = rb_q[7] & ~ncs_s2;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: table vectors, directed corner cases and
// randomized frames checked against a frame-level register model.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_err;

    spi_reg_writer dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .cipo           (cipo),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err_total = 0;
    logic [7:0] model_regs [5];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic        exp_err;
        logic [39:0] exp_regs;
    } vec_t;

    vec_t vecs [10];

    always @(negedge clk)
        if (frame_err === 1'b1)
            err_seen++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_pack();
        return {model_regs[4], model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    // Frame-level rules: only a complete 16-bit write to 0..4 lands; any other
    // non-empty length is an error.
    function automatic logic model_frame(input logic [15:0] f, input int n);
        int a;
        a = int'(f[14:8]);
        if (n == 16 && f[15] && a <= 4)
            model_regs[a] = f[7:0];
        return (n != 0 && n != 16);
    endfunction

    function automatic logic [7:0] model_readback(input logic [15:0] f);
        int a;
        a = int'(f[14:8]);
`ifdef SPI_READBACK_EN
        if (!f[15] && a <= 4)
            return model_regs[a];
`endif
        return 8'h00;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(5);
    endtask

    task automatic clock_bit(input logic b, output logic c);
        copi = b;
        wait_clk(5);
        c = cipo;
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
    endtask

    task automatic cs_high_check(input logic [39:0] old_regs, input logic exp_err, output logic err_obs);
        wait_clk(5);
        ncs = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check("regs_before_commit", dut_regs(), old_regs);
            check("err_early", frame_err, 1'b0);
        end
        @(negedge clk);
        err_obs = frame_err;
        check("regs_at_edge3", dut_regs(), model_pack());
        check("err_at_edge3", frame_err, exp_err);
        @(negedge clk);
        check("err_one_cycle", frame_err, 1'b0);
        check("cipo_idle", cipo, 1'b0);
        wait_clk(4);
    endtask

    task automatic send_frame(input logic [15:0] f, input int n, output logic [7:0] rb, output logic err_obs);
        logic [39:0] old;
        logic        e;
        logic        b;
        logic        c;
        old = model_pack();
        if (n == 16)
            exp_q.push_back(model_readback(f));
        rb = 8'h00;
        cs_low();
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? f[15 - i] : 1'b0;
            clock_bit(b, c);
            if (i >= 8 && i < 16)
                rb = {rb[6:0], c};
        end
        e = model_frame(f, n);
        if (e)
            exp_err_total++;
        cs_high_check(old, e, err_obs);
        if (n == 16)
            check("readback_byte", rb, exp_q.pop_front());
    endtask

    initial begin
        logic [7:0]  rb;
        logic        eo;
        logic        c;
        logic [15:0] f;
        int          n;
        int          r;

        vecs[0] = '{16'h80F0, 16, 1'b0, 40'h00_00_00_00_F0};
        vecs[1] = '{16'h8455, 16, 1'b0, 40'h55_00_00_00_F0};
        vecs[2] = '{16'h85AA, 16, 1'b0, 40'h55_00_00_00_F0};
        vecs[3] = '{16'h82FF, 15, 1'b1, 40'h55_00_00_00_F0};
        vecs[4] = '{16'h82FF, 17, 1'b1, 40'h55_00_00_00_F0};
        vecs[5] = '{16'h0233, 16, 1'b0, 40'h55_00_00_00_F0};
        vecs[6] = '{16'h8312, 16, 1'b0, 40'h55_12_00_00_F0};
        vecs[7] = '{16'h8000, 0,  1'b0, 40'h55_12_00_00_F0};
        vecs[8] = '{16'h81A5, 16, 1'b0, 40'h55_12_00_A5_F0};
        vecs[9] = '{16'h8000, 16, 1'b0, 40'h55_12_00_A5_00};

        for (int i = 0; i < 5; i++)
            model_regs[i] = 8'h00;

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        wait_clk(3);
        check("reset_regs", dut_regs(), 40'h0);
        check("reset_err", frame_err, 1'b0);
        check("reset_cipo", cipo, 1'b0);
        rst = 1'b0;
        wait_clk(3);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].frame, vecs[i].nbits, rb, eo);
            check("vec_regs", dut_regs(), vecs[i].exp_regs);
            check("vec_err", eo, vecs[i].exp_err);
        end

        // sclk toggling while deselected must be ignored
        repeat (3) begin
            sclk = 1'b1; wait_clk(5);
            sclk = 1'b0; wait_clk(5);
        end
        wait_clk(4);
        check("desel_sclk_regs", dut_regs(), model_pack());
        check("desel_sclk_err", err_seen, exp_err_total);

        // reset after 9 bits of 0x83C3, keep clocking, then deselect
        f = 16'h83C3;
        cs_low();
        for (int i = 0; i < 9; i++)
            clock_bit(f[15 - i], c);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            model_regs[i] = 8'h00;
        check("midframe_rst_regs", dut_regs(), 40'h0);
        check("midframe_rst_err", frame_err, 1'b0);
        for (int i = 9; i < 16; i++)
            clock_bit(f[15 - i], c);
        cs_high_check(40'h0, 1'b0, eo);
        check("post_rst_pwm_15_8", en_reg_pwm_15_8, 8'h00);
        send_frame(16'h8303, 16, rb, eo);
        check("after_rst_write", en_reg_pwm_15_8, 8'h03);

`ifdef SPI_READBACK_EN
        send_frame(16'h8166, 16, rb, eo);
        send_frame(16'h0100, 16, rb, eo);
        check("readback_0x66", rb, 8'h66);
        check("readback_regs_kept", en_reg_out_15_8, 8'h66);
`endif

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                n = 16;
            else if (r == 6)
                n = 0;
            else
                n = $urandom_range(1, 20);
            f[15]   = ($urandom_range(0, 3) != 0);
            f[14:8] = 7'($urandom_range(0, 7));
            f[7:0]  = 8'($urandom);
            send_frame(f, n, rb, eo);
        end

        check("err_pulse_total", err_seen, exp_err_total);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
